// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: fetches 1-bpp framebuffer words into a small FIFO and
// serialises them into RGB pixels aligned with the delayed sync outputs.
// Optional feature macro: PIXEL_UNDERRUN_FLAG_EN (sticky underrun flag).
module vga_pixel_fetch #(
  parameter int H_PIXELS   = 800,
  parameter int V_LINES    = 600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [2:0]  fg,
  input  logic [2:0]  bg,
  output logic        mem_req,
  output logic [16:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [2:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        underrun
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO_C = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
  localparam logic [16:0]      ADDR_MAX_C = 17'(H_PIXELS / 16 * V_LINES - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [16:0]      addr_q, addr_d;
  logic             discard_q, discard_d;
  logic             vblank_q;
  logic             vb_rise_s, active_s;
  logic             push_s, push_ok_s, pop_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]      fifo_mem_q [FIFO_DEPTH];
  logic [3:0]       pix_cnt_q, pix_cnt_d;
  logic [15:0]      shift_q, shift_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             hsync_q, vsync_q;

  assign vb_rise_s = vblank & ~vblank_q;
  assign active_s  = ~hblank & ~vblank;
  // A push never overflows: the FSM only requests while a slot is free.
  assign push_ok_s = push_s & ((count_q != DEPTH_C) | pop_s);

  assign mem_req   = (state_q == ST_REQ);
  assign mem_addr  = addr_q;
  assign rgb       = rgb_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

  // Fetch FSM: request while a FIFO slot is free; a request caught by a
  // frame resync still completes its handshake but its data is dropped.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    push_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q < DEPTH_C) state_d = ST_REQ;
        else                   state_d = ST_IDLE;
        if (vb_rise_s) addr_d = 17'd0;
        else           addr_d = addr_q;
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
          if (discard_q || vb_rise_s) begin
            addr_d = 17'd0;
          end else begin
            push_s = 1'b1;
            addr_d = (addr_q == ADDR_MAX_C) ? 17'd0 : addr_q + 17'd1;
          end
        end else begin
          state_d = ST_REQ;
          if (vb_rise_s) discard_d = 1'b1;
          else           discard_d = discard_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointer/occupancy update; a vblank rise flushes everything.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (vb_rise_s) begin
      count_d  = CNT_ZERO_C;
      wr_ptr_d = PTR_ZERO_C;
      rd_ptr_d = PTR_ZERO_C;
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      else           wr_ptr_d = wr_ptr_q;
      if (pop_s) rd_ptr_d = rd_ptr_q + PTR_ONE_C;
      else       rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE_C;
        2'b01:   count_d = count_q - CNT_ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // Pixel path: load a word every 16 active pixels, shift MSB-first to rgb.
  always_comb begin
    pop_s     = 1'b0;
    shift_d   = shift_q;
    pix_cnt_d = pix_cnt_q;
    rgb_d     = 3'b000;
    if (hblank)        pix_cnt_d = 4'd0;
    else if (active_s) pix_cnt_d = pix_cnt_q + 4'd1;
    else               pix_cnt_d = pix_cnt_q;
    if (active_s) begin
      if (pix_cnt_q == 4'd0) begin
        if (count_q != CNT_ZERO_C) begin
          pop_s   = 1'b1;
          shift_d = fifo_mem_q[rd_ptr_q];
        end else begin
          shift_d = 16'h0000;
        end
      end else begin
        shift_d = {shift_q[14:0], 1'b0};
      end
      rgb_d = shift_d[15] ? fg : bg;
    end else begin
      shift_d = shift_q;
      rgb_d   = 3'b000;
    end
  end

  // State, FIFO bookkeeping, pixel pipeline and sync delay registers.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= 17'd0;
      discard_q <= 1'b0;
      vblank_q  <= 1'b0;
      count_q   <= CNT_ZERO_C;
      wr_ptr_q  <= PTR_ZERO_C;
      rd_ptr_q  <= PTR_ZERO_C;
      pix_cnt_q <= 4'd0;
      shift_q   <= 16'h0000;
      rgb_q     <= 3'b000;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      vblank_q  <= vblank;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pix_cnt_q <= pix_cnt_d;
      shift_q   <= shift_d;
      rgb_q     <= rgb_d;
      hsync_q   <= hsync;
      vsync_q   <= vsync;
    end
  end

  // FIFO storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk_pixel) begin
    if (reset_n && push_ok_s) fifo_mem_q[wr_ptr_q] <= mem_data;
  end

`ifdef PIXEL_UNDERRUN_FLAG_EN
  logic starve_s;
  logic underrun_q;
  assign starve_s = active_s & (pix_cnt_q == 4'd0) & (count_q == CNT_ZERO_C);

  // Sticky underrun: set on a starved word load, cleared at frame resync.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n)       underrun_q <= 1'b0;
    else if (starve_s)  underrun_q <= 1'b1;
    else if (vb_rise_s) underrun_q <= 1'b0;
    else                underrun_q <= underrun_q;
  end
  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed, table-driven bench for vga_pixel_fetch with a behavioural memory.
module tb_vga_pixel_fetch;

  logic        clk_pixel = 1'b0;
  logic        reset_n, hsync, vsync, hblank, vblank;
  logic [2:0]  fg, bg;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [2:0]  rgb;
  logic        hsync_out, vsync_out, underrun;

`ifdef PIXEL_UNDERRUN_FLAG_EN
  localparam logic UF_EN = 1'b1;
`else
  localparam logic UF_EN = 1'b0;
`endif

  // 800x2 frame keeps the address wrap (99 -> 0) reachable in a short run.
  vga_pixel_fetch #(.H_PIXELS(800), .V_LINES(2), .FIFO_DEPTH(4)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .fg(fg), .bg(bg),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .underrun(underrun)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic       hb, vb, hs, vs;
    logic [2:0] exp_rgb;
    logic       exp_hs, exp_vs;
  } vec_t;

  vec_t tbl [36];

  int n_checks = 0;
  int n_fail   = 0;
  int ack_mode;      // 0 manual, 1 tied high, 2 ack after 3-cycle delay
  int req_cycles;
  bit mon_en;
  bit run_valid;
  int run_len, bad_len, bad_hold, runs_done, non_fg, bad_bg;
  bit saw_wrap;
  logic        prev_req;
  logic [16:0] prev_addr;
  logic [16:0] seen [$];
  logic [2:0]  exp4 [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pattern(input logic [16:0] a);
    if (a == 17'd0)      return 16'hA000;
    else if (a == 17'd1) return 16'h8001;
    else                 return 16'h5555;
  endfunction

  task automatic monitor();
    if (mon_en) begin
      if (mem_req && prev_req && (mem_addr !== prev_addr)) bad_hold++;
      if (mem_req && !prev_req) begin
        run_valid = 1'b1;
        run_len   = 1;
      end else if (mem_req) begin
        run_len++;
      end else if (prev_req && run_valid) begin
        runs_done++;
        if (run_len != 4) bad_len++;
      end
      if (prev_addr == 17'd99 && mem_addr == 17'd0) saw_wrap = 1'b1;
      if (!hblank && !vblank && rgb !== 3'b111) non_fg++;
    end
    prev_req  = mem_req;
    prev_addr = mem_addr;
  endtask

  task automatic update_mem();
    case (ack_mode)
      1: begin
        mem_ack  = 1'b1;
        mem_data = pattern(mem_addr);
      end
      2: begin
        if (mem_req) req_cycles++;
        else         req_cycles = 0;
        mem_ack  = mem_req && (req_cycles == 4);
        mem_data = 16'hFFFF;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
    monitor();
    update_mem();
  endtask

  task automatic pix(input logic hb, input logic vb);
    hblank = hb;
    vblank = vb;
    step();
  endtask

  initial begin
    // Pixel table: sync pass-through, word 16'hA000 then 16'h8001, blanking.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      tbl[2 + i]  = '{1'b0, 1'b0, 1'b0, 1'b0,
                      (i == 0 || i == 2) ? 3'b111 : 3'b001, 1'b0, 1'b0};
      tbl[18 + i] = '{1'b0, 1'b0, 1'b0, 1'b0,
                      (i == 0 || i == 15) ? 3'b111 : 3'b001, 1'b0, 1'b0};
    end
    tbl[34] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};
    tbl[35] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};
    exp4[0] = 3'b111; exp4[1] = 3'b001; exp4[2] = 3'b111; exp4[3] = 3'b001;

    reset_n = 1'b0; hsync = 1'b1; vsync = 1'b1; hblank = 1'b1; vblank = 1'b0;
    fg = 3'b111; bg = 3'b001; mem_ack = 1'b1; mem_data = 16'hA000;
    ack_mode = 1; req_cycles = 0; mon_en = 1'b0; run_valid = 1'b0;
    run_len = 0; bad_len = 0; bad_hold = 0; runs_done = 0; non_fg = 0;
    bad_bg = 0; saw_wrap = 1'b0; prev_req = 1'b0; prev_addr = 17'd0;

    // Reset state with sync inputs high and ack tied high.
    step(); step();
    check("rst_rgb", rgb, 3'b000);
    check("rst_hs", hsync_out, 1'b0);
    check("rst_vs", vsync_out, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 17'd0);
    check("rst_underrun", underrun, 1'b0);

    // Release: request rises one cycle later, addresses 0..3 then hold full.
    reset_n = 1'b1; vsync = 1'b0;
    step();
    check("rel_req", mem_req, 1'b1);
    check("rel_addr", mem_addr, 17'd0);
    check("rel_hs", hsync_out, 1'b1);
    check("rel_vs", vsync_out, 1'b0);
    seen.push_back(mem_addr);
    for (int i = 0; i < 13; i++) begin
      step();
      if (mem_req) seen.push_back(mem_addr);
    end
    check("fill_count", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("fill_addr%0d", i), seen[i], i);
    check("full_req", mem_req, 1'b0);
    check("full_addr", mem_addr, 17'd4);

    // Table-driven pixel/sync vectors.
    for (int i = 0; i < 36; i++) begin
      hblank = tbl[i].hb; vblank = tbl[i].vb;
      hsync  = tbl[i].hs; vsync  = tbl[i].vs;
      step();
      check($sformatf("vec%0d_rgb", i), rgb, tbl[i].exp_rgb);
      check($sformatf("vec%0d_hs", i), hsync_out, tbl[i].exp_hs);
      check($sformatf("vec%0d_vs", i), vsync_out, tbl[i].exp_vs);
    end
    check("no_underrun_table", underrun, 1'b0);

    // Resync while a request is pending; the late ack data is discarded.
    hsync = 1'b0; vsync = 1'b0; ack_mode = 1;
    for (int i = 0; i < 14; i++) pix(1'b1, 1'b0);
    check("refill_addr", mem_addr, 17'd4);
    check("refill_req", mem_req, 1'b0);
    ack_mode = 0; mem_ack = 1'b0;
    pix(1'b0, 1'b0);
    check("refill_pix", rgb, 3'b111);
    pix(1'b1, 1'b0); pix(1'b1, 1'b0);
    check("pend_req", mem_req, 1'b1);
    check("pend_addr", mem_addr, 17'd4);
    pix(1'b1, 1'b1);
    check("rise_req_held", mem_req, 1'b1);
    check("rise_addr_held", mem_addr, 17'd4);
    pix(1'b1, 1'b1);
    mem_ack = 1'b1; mem_data = 16'hFFFF;
    pix(1'b1, 1'b1);
    check("discard_req", mem_req, 1'b0);
    check("discard_addr", mem_addr, 17'd0);
    mem_ack = 1'b0;
    pix(1'b1, 1'b1);
    check("after_rise_req", mem_req, 1'b1);
    check("after_rise_addr", mem_addr, 17'd0);
    pix(1'b1, 1'b0); pix(1'b1, 1'b0);
    pix(1'b0, 1'b0);
    check("flushed_bg", rgb, 3'b001);
    check("underrun_set", underrun, UF_EN);

    // Starved line: bg pixels, underrun holds until the next vblank rise.
    for (int i = 0; i < 31; i++) begin
      pix(1'b0, 1'b0);
      if (rgb !== 3'b001) bad_bg++;
    end
    check("starve_line_bg", bad_bg, 0);
    check("starve_req_held", mem_req, 1'b1);
    pix(1'b1, 1'b0);
    check("underrun_hold", underrun, UF_EN);
    pix(1'b1, 1'b1);
    check("underrun_clear", underrun, 1'b0);

    // Reset pulse mid-line and mid-handshake; ack during/after reset ignored.
    pix(1'b1, 1'b0);
    pix(1'b0, 1'b0); pix(1'b0, 1'b0); pix(1'b0, 1'b0);
    reset_n = 1'b0; hsync = 1'b1; vsync = 1'b1; mem_ack = 1'b1; mem_data = 16'hFFFF;
    pix(1'b0, 1'b0);
    check("pulse_rgb", rgb, 3'b000);
    check("pulse_hs", hsync_out, 1'b0);
    check("pulse_vs", vsync_out, 1'b0);
    check("pulse_req", mem_req, 1'b0);
    check("pulse_addr", mem_addr, 17'd0);
    check("pulse_underrun", underrun, 1'b0);
    reset_n = 1'b1; hsync = 1'b0; vsync = 1'b0;
    pix(1'b1, 1'b0);
    check("restart_req", mem_req, 1'b1);
    check("restart_addr", mem_addr, 17'd0);
    ack_mode = 1; mem_data = pattern(mem_addr);
    for (int i = 0; i < 12; i++) pix(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pix(1'b0, 1'b0);
      check($sformatf("restart_pix%0d", i), rgb, exp4[i]);
    end

    // Full frame with 3-cycle ack delay: hold, no starvation, address wrap.
    ack_mode = 2; req_cycles = 0; mem_ack = 1'b0; mem_data = 16'hFFFF;
    pix(1'b1, 1'b1);
    mon_en = 1'b1; run_valid = 1'b0;
    for (int i = 0; i < 63; i++) pix(1'b1, 1'b1);
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < 48; i++) pix(1'b1, 1'b0);
      for (int i = 0; i < 800; i++) pix(1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) pix(1'b1, 1'b0);
    mon_en = 1'b0;
    check("frame_req_len", bad_len, 0);
    check("frame_addr_hold", bad_hold, 0);
    check("frame_wrap", saw_wrap, 1'b1);
    check("frame_non_fg", non_fg, 0);
    check("frame_runs", runs_done >= 100, 1'b1);
    check("frame_underrun", underrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 Parameter H_PIXELS, default 800: active pixels per line; SHALL be a multiple of 16.
REQ-002 Parameter V_LINES, default 600: active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 4: word FIFO depth; SHALL be a power of two, at least 2.
REQ-004 clk_pixel  in  1  pixel clock; sole clock.
REQ-005 reset_n  in  1  reset; synchronous and active-low.
REQ-006 hsync, vsync  in  1 each  sync from the upstream timing generator, already polarity-applied.
REQ-007 hblank, vblank  in  1 each  blanking flags from the upstream timing generator; a pixel is active when both are 0.
REQ-008 fg, bg  in  3 each  RGB colour for set and clear bits, respectively.
REQ-009 mem_req  out  1  word read request.
REQ-010 mem_addr  out  17  word address, frame-linear.
REQ-011 mem_ack  in  1  read complete; mem_data is valid in the same cycle.
REQ-012 mem_data  in  16  read data; 1 bpp; MSB is the leftmost pixel.
REQ-013 rgb  out  3  pixel colour.
REQ-014 hsync_out, vsync_out  out  1 each  hsync and vsync delayed to align with rgb.
REQ-015 underrun  out  1  sticky FIFO-underrun flag.

Function
REQ-016 rgb, hsync_out and vsync_out SHALL be registered, with exactly 1 cycle latency from the corresponding hsync/vsync/hblank/vblank sample.
REQ-017 rgb SHALL be 3'b000 for any cycle whose sampled hblank or vblank was 1.
REQ-018 Fetch FSM states: IDLE, REQ.
  - IDLE to REQ: the FIFO has a free slot, counting any in-flight word.
  - REQ to IDLE: the cycle mem_ack=1 is sampled.
REQ-019 In REQ, mem_req SHALL be 1 and mem_addr SHALL be held stable; at most one request is outstanding.
REQ-020 An ack in the same cycle mem_req first rises SHALL complete that request.
REQ-021 mem_addr SHALL increment by 1 per completed request and wrap to 0 after H_PIXELS/16*V_LINES-1 (29999 at defaults).
REQ-022 When mem_ack=1, mem_data SHALL be pushed to the FIFO.
REQ-023 A pushed word SHALL be poppable no earlier than the next cycle.
REQ-024 A 4-bit pixel counter SHALL reset to 0 whenever hblank=1, and SHALL increment on each active pixel, modulo 16.
REQ-025 On an active pixel with counter=0, the FIFO head SHALL be popped into a 16-bit shifter.
  - The MSB SHALL drive rgb: fg if 1, bg if 0.
  - The shifter SHALL shift left 1 bit per subsequent active pixel.
REQ-026 If the FIFO is empty at a counter=0 pop, the shifter SHALL load 16'h0000 (bg pixels), no pop SHALL occur, and an underrun SHALL be recorded.
REQ-027 On the rising edge of vblank (vblank=1, previous sample 0), the block SHALL frame-resync:
  - flush the FIFO;
  - set mem_addr to 0;
  - if in REQ, complete that handshake but discard its data, then issue the next request at address 0.
REQ-028 A simultaneous push and pop SHALL both take effect; FIFO occupancy SHALL never exceed FIFO_DEPTH.

Reset
REQ-029 While reset_n=0 at a clk_pixel edge, the following SHALL hold:
  - rgb=0, hsync_out=0, vsync_out=0;
  - mem_req=0, mem_addr=0, underrun=0;
  - FSM=IDLE, FIFO empty, pixel counter=0, shifter=0, vblank edge detector=0.
REQ-030 Reset asserted mid-handshake SHALL drop mem_req the following cycle; any ack arriving during or after reset for that request SHALL be ignored.

Configuration
REQ-031 With macro PIXEL_UNDERRUN_FLAG_EN defined, underrun SHALL set on any REQ-026 event and SHALL clear at the vblank rising edge. A set on the same cycle as the clear SHALL win.
REQ-032 Without PIXEL_UNDERRUN_FLAG_EN, underrun SHALL be constant 0 and no underrun logic SHALL be synthesised.

Verification
REQ-033 Reset, then release with mem_ack tied 1:
  - mem_req rises 1 cycle after release;
  - mem_addr steps 0,1,2,3, then holds with FIFO full (4 words).
REQ-034 Memory returns 16'hA000 at address 0, fg=3'b111, bg=3'b001, first active line:
  - rgb = 111, 001, 111, then 001 for 13 pixels, starting 1 cycle after hblank falls.
REQ-035 Memory acks with a 3-cycle delay:
  - mem_req and mem_addr are held 4 cycles per word;
  - no underrun across a full 800x600 frame;
  - mem_addr wraps 29999 to 0.
REQ-036 mem_ack held 0 for a whole line, macro defined:
  - bg pixels are output;
  - underrun=1 from the first starved pop until the next vblank rise.
REQ-037 vblank rises while in REQ; ack arrives 2 cycles later with data 16'hFFFF:
  - the data is discarded;
  - the next mem_addr is 0;
  - the FIFO is empty at the rise.
REQ-038 reset_n pulsed low for 1 cycle mid-line:
  - all outputs at REQ-029 values;
  - fetching restarts at address 0.
